// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared entry type, constants and helpers for the fetch buffer
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Redirect targets are forced onto a word boundary before fetch resumes.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// rtl/fetch_buffer_if.sv - imem, redirect and decode-side signal bundle of the fetch buffer
interface fetch_buffer_if #(
  parameter int DEPTH = 4
);

  localparam int CW = $clog2(DEPTH + 1);

  // instruction ROM side
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;

  // execute-stage redirect
  logic          redirect_valid;
  logic [31:0]   redirect_pc;

  // decode side
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [CW-1:0] count;

  // the fetch buffer itself
  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, count,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  // the surrounding core / ROM
  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, count,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of {instr, pc} entries with flush priority over push/pop
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two; flush empties in one edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  // Entry storage; a flushed push never lands.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - fetch PC, single outstanding imem read and decode queue; FETCH_BUF_BYPASS_EN adds response bypass
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  fetch_buffer_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;

  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  rsp_entry;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;

  logic          bypass;
  logic          out_valid_c;
  logic          pop;
  logic          issue;
  logic [OW-1:0] occupancy;

  assign fifo_empty      = (fifo_count == '0);
  assign rsp_entry.instr = bus.imem_rdata;
  assign rsp_entry.pc    = inflight_pc;

`ifdef FETCH_BUF_BYPASS_EN
  assign bypass = !rst && fifo_empty && inflight && !bus.redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  // Decode sees the FIFO head first, otherwise a bypassed response, otherwise a NOP bubble.
  always_comb begin
    out_valid_c   = 1'b0;
    bus.out_instr = NOP_INSTR;
    bus.out_pc    = 32'h0;
    if (!rst && !fifo_empty) begin
      out_valid_c   = 1'b1;
      bus.out_instr = fifo_head.instr;
      bus.out_pc    = fifo_head.pc;
    end else if (bypass) begin
      out_valid_c   = 1'b1;
      bus.out_instr = rsp_entry.instr;
      bus.out_pc    = rsp_entry.pc;
    end
  end

  assign bus.out_valid = out_valid_c;
  assign bus.count     = fifo_count;

  // A redirect kills the handshake, so nothing is consumed in that cycle.
  assign pop      = out_valid_c && bus.out_ready && !bus.redirect_valid;
  assign fifo_pop = pop && !fifo_empty;

  // A bypassed response that decode takes right away never occupies a slot.
  assign fifo_push = inflight && !bus.redirect_valid && !(bypass && pop);

  // Credit: entries held plus the one read in flight, minus what leaves this cycle.
  assign occupancy = OW'(fifo_count) + OW'(inflight) - OW'(pop);
  assign issue     = !rst && !bus.redirect_valid && (occupancy < OW'(DEPTH));

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc;

  // Fetch PC and the single outstanding-read tracker; redirect beats everything but reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= word_align(bus.redirect_pc);
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'(INSTR_BYTES);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (fifo_push),
    .push_data (rsp_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - randomized bench with a queue-based reference model for fetch_buffer
module tb_fetch_buffer;
  import fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] PC2   = 32'hFFFF_FFF8;
`ifdef FETCH_BUF_BYPASS_EN
  localparam int FIRST_VALID = 1;
  localparam int REDIR_LAT   = 2;
  localparam bit BYP         = 1'b1;
`else
  localparam int FIRST_VALID = 2;
  localparam int REDIR_LAT   = 3;
  localparam bit BYP         = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_buffer_if #(.DEPTH(DEPTH)) bus ();
  fetch_buffer_if #(.DEPTH(DEPTH)) bus2 ();

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut  (.clk(clk), .rst(rst), .bus(bus));
  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(PC2))   dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic        d_redir = 1'b0;
  logic [31:0] d_rpc   = 32'h0;
  logic        d_ready = 1'b0;

  logic        prev_req   = 1'b0;
  logic        prev_req2  = 1'b0;
  logic [31:0] prev_addr  = 32'h0;
  logic [31:0] prev_addr2 = 32'h0;

  fetch_entry_t mq[$];
  bit           m_inflight    = 1'b0;
  logic [31:0]  m_inflight_pc = 32'h0;
  logic [31:0]  m_fetch_pc    = 32'h0;
  logic [31:0]  accepted[$];
  logic [31:0]  q2[$];

  logic        o_valid;
  logic        o_req;
  logic [31:0] o_pc;
  logic [31:0] o_addr;
  int          o_count;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a >> 2) * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    int           n;
    bit           byp;
    bit           ev;
    bit           pop;
    bit           er;
    logic [31:0]  ei;
    logic [31:0]  ep;
    fetch_entry_t e;
    n   = mq.size();
    byp = BYP && !rst && (n == 0) && m_inflight && !d_redir;
    ev  = !rst && ((n > 0) || byp);
    ei  = NOP_INSTR;
    ep  = 32'h0;
    if (ev) begin
      if (n > 0) begin
        ei = mq[0].instr;
        ep = mq[0].pc;
      end else begin
        ei = rom(m_inflight_pc);
        ep = m_inflight_pc;
      end
    end
    pop = ev && d_ready && !d_redir;
    er  = !rst && !d_redir && ((n + int'(m_inflight) - int'(pop)) < DEPTH);
    check("out_valid", 32'(bus.out_valid), 32'(ev));
    check("out_instr", bus.out_instr, ei);
    check("out_pc", bus.out_pc, ep);
    check("imem_req", 32'(bus.imem_req), 32'(er));
    if (er) check("imem_addr", bus.imem_addr, m_fetch_pc);
    if (!rst) check("count", 32'(bus.count), 32'(n));
    if (pop) accepted.push_back(ep);
    if (rst) begin
      mq.delete();
      m_inflight = 1'b0;
      m_fetch_pc = 32'h0;
    end else if (d_redir) begin
      mq.delete();
      m_inflight = 1'b0;
      m_fetch_pc = {d_rpc[31:2], 2'b00};
    end else begin
      if (pop && n > 0) void'(mq.pop_front());
      if (m_inflight && !(byp && pop)) begin
        e.instr = rom(m_inflight_pc);
        e.pc    = m_inflight_pc;
        mq.push_back(e);
      end
      if (er) begin
        m_inflight_pc = m_fetch_pc;
        m_fetch_pc    = m_fetch_pc + 32'd4;
        m_inflight    = 1'b1;
      end else begin
        m_inflight = 1'b0;
      end
    end
  endtask

  task automatic step();
    bus.redirect_valid  = d_redir;
    bus.redirect_pc     = d_rpc;
    bus.out_ready       = d_ready;
    bus.imem_rdata      = prev_req ? rom(prev_addr) : $urandom();
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0;
    bus2.out_ready      = 1'b1;
    bus2.imem_rdata     = prev_req2 ? rom(prev_addr2) : $urandom();
    #1;
    o_valid = bus.out_valid;
    o_pc    = bus.out_pc;
    o_req   = bus.imem_req;
    o_addr  = bus.imem_addr;
    o_count = int'(bus.count);
    compare();
    if (!rst && bus2.out_valid && q2.size() < 3) q2.push_back(bus2.out_pc);
    prev_req   = bus.imem_req;
    prev_addr  = bus.imem_addr;
    prev_req2  = bus2.imem_req;
    prev_addr2 = bus2.imem_addr;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    d_redir = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int  nreq;
    int  thresh;
    bit  found;

    // reset, then free-running with decode always ready
    do_reset();
    d_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) begin
        check("p1_req0", 32'(o_req), 32'd1);
        check("p1_addr0", o_addr, 32'h0);
      end
      if (i == FIRST_VALID - 1) check("p1_valid_before", 32'(o_valid), 32'd0);
      if (i == FIRST_VALID) begin
        check("p1_first_valid", 32'(o_valid), 32'd1);
        check("p1_first_pc", o_pc, 32'h0);
      end
      if (i == FIRST_VALID + 1) check("p1_second_pc", o_pc, 32'h4);
      if (i >= 4) check("p1_steady_count", 32'(o_count <= 1), 32'd1);
    end

    // decode stalled: credit stops issue at DEPTH, then drains in order
    do_reset();
    d_ready = 1'b0;
    nreq    = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_req) nreq++;
    end
    check("p2_req_count", 32'(nreq), 32'(DEPTH));
    check("p2_count_full", 32'(o_count), 32'(DEPTH));
    check("p2_req_stalled", 32'(o_req), 32'd0);
    accepted.delete();
    d_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) begin
        check("p2_resume_req", 32'(o_req), 32'd1);
        check("p2_resume_addr", o_addr, 32'h10);
      end
    end
    check("p2_accepted_n", 32'(accepted.size() >= 8), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i < accepted.size()) check("p2_order", accepted[i], 32'(4 * i));
    end

    // redirect with three queued entries and a read in flight
    do_reset();
    d_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    d_redir = 1'b1;
    d_rpc   = 32'h40;
    d_ready = 1'b1;
    step();
    check("p3_count_at_n", 32'(o_count), 32'd3);
    check("p3_no_req_at_n", 32'(o_req), 32'd0);
    d_redir = 1'b0;
    for (int k = 1; k <= REDIR_LAT + 1; k++) begin
      step();
      if (k == 1) begin
        check("p3_count_cleared", 32'(o_count), 32'd0);
        check("p3_req_target", 32'(o_req), 32'd1);
        check("p3_addr_target", o_addr, 32'h40);
      end
      if (k < REDIR_LAT) check("p3_bubble", 32'(o_valid), 32'd0);
      if (k == REDIR_LAT) begin
        check("p3_valid_target", 32'(o_valid), 32'd1);
        check("p3_pc_target", o_pc, 32'h40);
      end
      if (k == REDIR_LAT + 1) check("p3_pc_next", o_pc, 32'h44);
    end

    // back-to-back redirects, last one (misaligned) wins
    d_redir = 1'b1;
    d_rpc   = 32'h100;
    step();
    d_rpc = 32'h43;
    step();
    d_redir = 1'b0;
    step();
    check("p4_req", 32'(o_req), 32'd1);
    check("p4_addr_aligned", o_addr, 32'h40);
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (o_valid && !found) begin
        found = 1'b1;
        check("p4_first_pc", o_pc, 32'h40);
      end
    end
    check("p4_found_valid", 32'(found), 32'd1);

    // reset asserted with two entries queued
    do_reset();
    d_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("p5_count_before", 32'(o_count), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("p5_valid_after", 32'(o_valid), 32'd0);
    check("p5_count_after", 32'(o_count), 32'd0);
    check("p5_req_after", 32'(o_req), 32'd1);
    check("p5_addr_after", o_addr, 32'h0);

    // randomized traffic: ready density, redirects and occasional resets
    thresh = 7;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) thresh = $urandom_range(0, 10);
      rst     = ($urandom_range(0, 199) == 0);
      d_redir = ($urandom_range(0, 19) == 0);
      d_rpc   = $urandom();
      if ($urandom_range(0, 3) == 0) d_rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      d_ready = ($urandom_range(0, 9) < thresh);
      step();
    end
    rst     = 1'b0;
    d_redir = 1'b0;
    step();

    // second instance started at FFFF_FFF8 and wraps through zero
    check("p6_wrap_n", 32'(q2.size()), 32'd3);
    if (q2.size() >= 3) begin
      check("p6_wrap_0", q2[0], 32'hFFFF_FFF8);
      check("p6_wrap_1", q2[1], 32'hFFFF_FFFC);
      check("p6_wrap_2", q2[2], 32'h0000_0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
